peridot_cam_avs_mb: RTL and testbench



---
 rtl/peridot_cam_mb_pkg.sv | 12 +
 rtl/peridot_cam_sync_edge.sv | 24 ++
 rtl/peridot_cam_avs_mb.sv | 124 ++++++++++++
 tb/tb_peridot_cam_avs_mb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/peridot_cam_mb_pkg.sv
// peridot_cam_mb_pkg: register offsets, ctrl bit positions and FSM states for the camera control block
package peridot_cam_mb_pkg;
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_CYCLE  = 3'd1;
   localparam logic [2:0] REG_STATUS = 3'd2;
   localparam int CTRL_IRQENA = 31;
   localparam int CTRL_IRQREQ = 30;
   localparam int CTRL_OVFREQ = 29;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_RUN    = 0;
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE} state_t;
endpackage

// File: rtl/peridot_cam_sync_edge.sv
// peridot_cam_sync_edge: multi-flop synchroniser followed by a rising-edge detector
module peridot_cam_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic avs_clk_sig,
   input  logic reset_sig,
   input  logic din,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   // shift the async input through the chain and keep the last synchronised value for edge detect
   always_ff @(posedge avs_clk_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         sync_q <= {SYNC_STAGES{RESET_VALUE}};
         prev_q <= RESET_VALUE;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/peridot_cam_avs_mb.sv
// peridot_cam_avs_mb: Avalon-MM control/status for multi-buffer camera capture with continuous mode
module peridot_cam_avs_mb #(
   parameter int NUM_BUFFERS = 4,
   parameter int ADDR_ALIGN  = 6,
   parameter int CYCLE_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   avs_s1_clk,
   input  logic                   csi_global_reset_n,
   input  logic [2:0]             avs_s1_address,
   input  logic                   avs_s1_write,
   input  logic [31:0]            avs_s1_writedata,
   input  logic                   avs_s1_read,
   output logic [31:0]            avs_s1_readdata,
   output logic                   avs_s1_irq,
   input  logic                   framesync,
   input  logic                   done,
   output logic                   start,
   output logic                   infiforeset,
   output logic [31:0]            capaddress_top,
   output logic [CYCLE_WIDTH-1:0] capcycle_num,
   output logic [1:0]             bufindex
);
   import peridot_cam_mb_pkg::*;
   localparam logic [2:0] NB       = 3'(NUM_BUFFERS);
   localparam logic [1:0] LAST_IDX = 2'(NUM_BUFFERS - 1);
   state_t                state, state_nx;
   logic                  fs_rise, dn_rise;
   logic                  irqena, irqreq, ovfreq, cont, stop_pending;
   logic [15:0]           frame_cnt;
   logic [1:0]            last_idx;
   logic [31:ADDR_ALIGN]  buf_addr [4];
   logic                  ctrl_wr, run_wd, stop_wr, cap_done, advance, slot_ok;
   logic                  unused_read;
   assign unused_read = avs_s1_read;
   peridot_cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_fs_sync (
      .avs_clk_sig(avs_s1_clk), .reset_sig(csi_global_reset_n), .din(framesync), .rise(fs_rise));
   peridot_cam_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_dn_sync (
      .avs_clk_sig(avs_s1_clk), .reset_sig(csi_global_reset_n), .din(done), .rise(dn_rise));
   assign ctrl_wr  = avs_s1_write && avs_s1_address == REG_CTRL;
   assign run_wd   = avs_s1_writedata[CTRL_RUN];
   assign stop_wr  = ctrl_wr && !run_wd;
   assign cap_done = state == ST_CAPTURE && dn_rise;
   // a stop written in the same cycle as done still ends the ring
   assign advance  = cont && !stop_pending && !stop_wr;
   assign slot_ok  = avs_s1_address[2] && {1'b0, avs_s1_address[1:0]} < NB;
   assign capaddress_top = {buf_addr[bufindex], {ADDR_ALIGN{1'b0}}};
   assign avs_s1_irq     = irqena & (irqreq | ovfreq);
   // state register
   always_ff @(posedge avs_s1_clk or negedge csi_global_reset_n) begin
      if (!csi_global_reset_n) state <= ST_IDLE;
      else state <= state_nx;
   end
   // next state and start pulse; an abort write beats a simultaneous framesync
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         ST_IDLE:    if (ctrl_wr && run_wd) state_nx = ST_ARMED;
         ST_ARMED:   if (stop_wr) state_nx = ST_IDLE;
                     else if (fs_rise) begin
                        state_nx = ST_CAPTURE;
                        start    = 1'b1;
                     end
         ST_CAPTURE: if (dn_rise) state_nx = advance ? ST_ARMED : ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end
   // capture bookkeeping: buffer ring, frame counter, interrupt flags (hardware set beats CPU clear)
   always_ff @(posedge avs_s1_clk or negedge csi_global_reset_n) begin
      if (!csi_global_reset_n) begin
         infiforeset  <= 1'b1;
         bufindex     <= '0;
         stop_pending <= 1'b0;
         frame_cnt    <= '0;
         last_idx     <= '0;
         irqena       <= 1'b0;
         irqreq       <= 1'b0;
         ovfreq       <= 1'b0;
         cont         <= 1'b0;
      end else begin
         if (state == ST_IDLE && ctrl_wr && run_wd) begin
            bufindex     <= '0;
            stop_pending <= 1'b0;
         end
         if (state == ST_CAPTURE && stop_wr) stop_pending <= 1'b1;
         if (start) infiforeset <= 1'b0;
         if (ctrl_wr) begin
            irqena <= avs_s1_writedata[CTRL_IRQENA];
            if (!avs_s1_writedata[CTRL_IRQREQ]) irqreq <= 1'b0;
            if (!avs_s1_writedata[CTRL_OVFREQ]) ovfreq <= 1'b0;
            if (state == ST_IDLE) cont <= avs_s1_writedata[CTRL_CONT];
         end
         if (cap_done) begin
            infiforeset <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            last_idx    <= bufindex;
            irqreq      <= 1'b1;
            if (irqreq) ovfreq <= 1'b1;
            if (advance) bufindex <= bufindex == LAST_IDX ? 2'd0 : bufindex + 2'd1;
         end
      end
   end
   // CPU-written cycle count and buffer addresses; unimplemented slots never load
   always_ff @(posedge avs_s1_clk or negedge csi_global_reset_n) begin
      if (!csi_global_reset_n) begin
         capcycle_num <= '0;
         for (int i = 0; i < 4; i++) buf_addr[i] <= '0;
      end else begin
         if (avs_s1_write && avs_s1_address == REG_CYCLE) capcycle_num <= avs_s1_writedata[CYCLE_WIDTH-1:0];
         if (avs_s1_write && slot_ok) buf_addr[avs_s1_address[1:0]] <= avs_s1_writedata[31:ADDR_ALIGN];
      end
   end
   // combinational read mux
   always_comb begin
      avs_s1_readdata = '0;
      case (avs_s1_address)
         REG_CTRL:   avs_s1_readdata = {irqena, irqreq, ovfreq, 26'd0, cont, state == ST_IDLE, state != ST_IDLE};
         REG_CYCLE:  avs_s1_readdata = 32'(capcycle_num);
         REG_STATUS: avs_s1_readdata = {14'd0, last_idx, frame_cnt};
         default:    if (slot_ok) avs_s1_readdata = {buf_addr[avs_s1_address[1:0]], {ADDR_ALIGN{1'b0}}};
      endcase
   end
endmodule

// File: tb/tb_peridot_cam_avs_mb.sv
// tb_peridot_cam_avs_mb: directed self-checking bench for the multi-buffer camera control block
module tb_peridot_cam_avs_mb;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [2:0]  address = '0;
   logic        write = 1'b0, read = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        irq, framesync = 1'b0, done = 1'b0, start, infiforeset;
   logic [31:0] capaddress_top;
   logic [15:0] capcycle_num;
   logic [1:0]  bufindex;
   int          tests = 0, fails = 0, start_cnt = 0;
   logic [31:0] addr_tbl [3] = '{32'h10000040, 32'h20000080, 32'h30000000};
   logic [1:0]  idx_tbl [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
   peridot_cam_avs_mb #(.NUM_BUFFERS(3), .ADDR_ALIGN(6), .CYCLE_WIDTH(16), .SYNC_STAGES(2)) dut (
      .avs_s1_clk(clk), .csi_global_reset_n(rst_n), .avs_s1_address(address), .avs_s1_write(write),
      .avs_s1_writedata(writedata), .avs_s1_read(read), .avs_s1_readdata(readdata), .avs_s1_irq(irq),
      .framesync(framesync), .done(done), .start(start), .infiforeset(infiforeset),
      .capaddress_top(capaddress_top), .capcycle_num(capcycle_num), .bufindex(bufindex));
   always #5 clk = ~clk;
   always @(negedge clk) if (start) start_cnt++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask
   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      @(negedge clk);
      address = a;
      #1 chk(tag, readdata, exp);
   endtask
   task automatic pulse_fs();
      @(negedge clk) framesync = 1'b1;
      repeat (5) @(negedge clk);
      framesync = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   task automatic pulse_done();
      @(negedge clk) done = 1'b1;
      repeat (5) @(negedge clk);
      done = 1'b0;
      repeat (4) @(negedge clk);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      rd("reset_ctrl", 3'd0, 32'h00000002);
      chk("reset_fiforst", 32'(infiforeset), 32'd1);
      chk("reset_start", 32'(start_cnt), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);
      rd("reset_status", 3'd2, 32'h0);
      pulse_fs();
      pulse_done();
      chk("idle_nostart", 32'(start_cnt), 32'd0);
      rd("idle_status", 3'd2, 32'h0);
      wr(3'd4, 32'h10000040);
      wr(3'd5, 32'h200000BF);
      wr(3'd6, 32'h30000000);
      wr(3'd7, 32'hFFFFFFFF);
      wr(3'd3, 32'hFFFFFFFF);
      rd("buf1_align", 3'd5, 32'h20000080);
      rd("slot3_ignored", 3'd7, 32'h0);
      rd("reserved_zero", 3'd3, 32'h0);
      wr(3'd1, 32'h00000100);
      chk("cycle_out", 32'(capcycle_num), 32'h00000100);
      wr(3'd0, 32'h80000001);
      rd("armed_ctrl", 3'd0, 32'h80000001);
      pulse_fs();
      chk("oneshot_start", 32'(start_cnt), 32'd1);
      chk("oneshot_fifo_run", 32'(infiforeset), 32'd0);
      chk("oneshot_addr", capaddress_top, 32'h10000040);
      pulse_done();
      chk("oneshot_irq", 32'(irq), 32'd1);
      chk("oneshot_fiforst", 32'(infiforeset), 32'd1);
      rd("oneshot_status", 3'd2, 32'h00000001);
      rd("oneshot_ctrl", 3'd0, 32'hC0000002);
      wr(3'd0, 32'h80000000);
      rd("irq_clear_ctrl", 3'd0, 32'h80000002);
      chk("irq_clear", 32'(irq), 32'd0);
      wr(3'd0, 32'h80000005);
      rd("cont_ctrl", 3'd0, 32'h80000005);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cont_idx%0d", k), 32'(bufindex), 32'(idx_tbl[k]));
         chk($sformatf("cont_addr%0d", k), capaddress_top, addr_tbl[idx_tbl[k]]);
         pulse_fs();
         pulse_done();
         rd($sformatf("cont_status%0d", k), 3'd2, {14'd0, idx_tbl[k], 16'(k + 2)});
         wr(3'd0, 32'h80000001);
      end
      rd("cont_end_ctrl", 3'd0, 32'h80000005);
      chk("cont_end_idx", 32'(bufindex), 32'd1);
      chk("cont_starts", 32'(start_cnt), 32'd5);
      pulse_fs();
      pulse_done();
      pulse_fs();
      pulse_done();
      rd("ovf_ctrl", 3'd0, 32'hE0000005);
      chk("ovf_irq", 32'(irq), 32'd1);
      rd("ovf_status", 3'd2, 32'h00020007);
      wr(3'd0, 32'h80000000);
      rd("ovf_clear_ctrl", 3'd0, 32'h80000006);
      chk("ovf_clear_irq", 32'(irq), 32'd0);
      wr(3'd0, 32'h80000005);
      chk("rearm_idx", 32'(bufindex), 32'd0);
      pulse_fs();
      wr(3'd0, 32'h80000004);
      rd("stop_pending_ctrl", 3'd0, 32'h80000005);
      pulse_done();
      rd("stop_ctrl", 3'd0, 32'hC0000006);
      chk("stop_idx", 32'(bufindex), 32'd0);
      rd("stop_status", 3'd2, 32'h00000008);
      wr(3'd0, 32'h00000001);
      @(negedge clk) framesync = 1'b1;
      @(negedge clk);
      @(negedge clk);
      address = 3'd0; writedata = 32'h0; write = 1'b1;
      #1 chk("abort_nostart", 32'(start), 32'd0);
      @(negedge clk) write = 1'b0;
      repeat (4) @(negedge clk);
      framesync = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_starts", 32'(start_cnt), 32'd8);
      rd("abort_ctrl", 3'd0, 32'h00000002);
      wr(3'd0, 32'h00000001);
      pulse_fs();
      chk("mid_fifo_run", 32'(infiforeset), 32'd0);
      @(negedge clk) done = 1'b1;
      #3 rst_n = 1'b0;
      #1 chk("async_fiforst", 32'(infiforeset), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      rd("post_reset_ctrl", 3'd0, 32'h00000002);
      rd("post_reset_status", 3'd2, 32'h0);
      done = 1'b0;
      repeat (4) @(negedge clk);
      rd("no_spurious_done", 3'd2, 32'h0);
      chk("post_reset_starts", 32'(start_cnt), 32'd9);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
